// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vram_pkg
//  Purpose  : Shared types and constants for the vector-RAM arbiter slice.
//             CPU window into vector RAM is VRAM_BASE .. VRAM_BASE + 8 KB - 1;
//             all addresses carried on the arbiter ports are offsets from
//             VRAM_BASE.
//  Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam logic [15:0] VRAM_BASE   = 16'h2000;
    localparam int          VRAM_ADDR_W = 13;

    // Owner tag of the read currently in flight through the BRAM pipeline.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_VG   = 2'b10
    } owner_t;

    typedef enum logic [0:0] {
        NORMAL    = 1'b0,
        CPU_BURST = 1'b1
    } arb_state_t;

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_rd_return.sv
`default_nettype none
// ============================================================================
//  Module   : vram_rd_return
//  Purpose  : Read-return pipeline. Remembers which requester owns the read
//             issued this cycle, then steers the 1-cycle-latency BRAM data to
//             that requester next cycle and keeps it held until that
//             requester's next read completes.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             cpu_rd, vg_rd   - a read was granted this cycle (one-hot)
//             bram_rdata      - BRAM read data (valid the cycle after grant)
//             cpu_rvalid/rdata, vg_rvalid/rdata - per-requester return
//  Revision : 1.0 - initial release
// ============================================================================
module vram_rd_return
    import vram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              vg_rd,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              vg_rvalid,
    output logic [DATA_W-1:0] vg_rdata
);

    owner_t            owner;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] vg_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (cpu_rd) begin
            owner <= OWN_CPU;
        end else if (vg_rd) begin
            owner <= OWN_VG;
        end else begin
            owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_hold <= '0;
            vg_hold  <= '0;
        end else begin
            if (owner == OWN_CPU) cpu_hold <= bram_rdata;
            if (owner == OWN_VG)  vg_hold  <= bram_rdata;
        end
    end

    // The returning word is passed straight through in its valid cycle so
    // no extra latency is added; the hold register keeps it afterwards.
    // A reset in the return cycle suppresses the pending rvalid.
    assign cpu_rvalid = (owner == OWN_CPU) && !rst;
    assign vg_rvalid  = (owner == OWN_VG)  && !rst;
    assign cpu_rdata  = cpu_rvalid ? bram_rdata : cpu_hold;
    assign vg_rdata   = vg_rvalid  ? bram_rdata : vg_hold;

endmodule : vram_rd_return
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares the single vector-RAM BRAM port between the 6502 side
//             and the vector-generator fetch engine. VG has default priority;
//             a saturating starvation counter lets the CPU force a win and
//             then hold the port for a short burst.
//  Ports    : clk, rst                         - clock, sync active-high reset
//             cpu_req/we/addr/wdata, cpu_gnt   - CPU request / grant
//             cpu_rvalid, cpu_rdata            - CPU read return
//             vg_req/addr, vg_gnt              - VG read request / grant
//             vg_rvalid, vg_rdata              - VG read return
//             bram_en/we/addr/wdata, bram_rdata- shared BRAM port
//             stat_cpu_wr_cnt, stat_starve_hits- only with VRAM_ARB_STATS_EN
//  Config   : `define VRAM_ARB_STATS_EN adds the two saturating statistics
//             counters and their output ports.
//  Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W        = VRAM_ADDR_W,
    parameter int DATA_W        = 8,
    parameter int STARVE_MAX    = 4,
    parameter int CPU_BURST_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vg_req,
    input  logic [ADDR_W-1:0] vg_addr,
    output logic              vg_gnt,
    output logic              vg_rvalid,
    output logic [DATA_W-1:0] vg_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_wr_cnt,
    output logic [15:0]       stat_starve_hits
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(CPU_BURST_LEN + 1);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LEN_C  = BW'(CPU_BURST_LEN);

    arb_state_t    state, state_nx;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt, burst_nx;
    logic          cpu_win, vg_win;
    logic          normal_arb;
    logic          forced;

    // A burst that has run out (length reached or CPU gone) falls back to
    // ordinary arbitration in the same cycle, so VG loses no slot.
    assign normal_arb = (state == NORMAL) || !cpu_req || (burst_cnt == BURST_LEN_C);
    assign forced     = !rst && normal_arb && cpu_req && (starve_cnt == STARVE_MAX_C);

    always_comb begin
        cpu_win  = 1'b0;
        vg_win   = 1'b0;
        state_nx = state;
        burst_nx = burst_cnt;
        if (!rst) begin
            if (normal_arb) begin
                state_nx = NORMAL;
                burst_nx = '0;
                if (forced) begin
                    cpu_win  = 1'b1;
                    state_nx = CPU_BURST;
                    burst_nx = BW'(1);
                end else if (vg_req) begin
                    vg_win = 1'b1;
                end else if (cpu_req) begin
                    cpu_win = 1'b1;
                end
            end else begin
                cpu_win  = 1'b1;
                burst_nx = burst_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NORMAL;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (cpu_win) begin
            starve_cnt <= '0;
        end else if (cpu_req && (starve_cnt != STARVE_MAX_C)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign cpu_gnt    = cpu_win;
    assign vg_gnt     = vg_win;
    assign bram_en    = cpu_win | vg_win;
    assign bram_we    = cpu_win & cpu_we;
    assign bram_addr  = cpu_win ? cpu_addr : (vg_win ? vg_addr : '0);
    assign bram_wdata = cpu_win ? cpu_wdata : '0;

    vram_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk        (clk),
        .rst        (rst),
        .cpu_rd     (cpu_win & ~cpu_we),
        .vg_rd      (vg_win),
        .bram_rdata (bram_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vg_rvalid  (vg_rvalid),
        .vg_rdata   (vg_rdata)
    );

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cpu_wr_cnt  <= '0;
            stat_starve_hits <= '0;
        end else begin
            if (cpu_win && cpu_we && (cpu_wdata != '0) && (stat_cpu_wr_cnt != 16'hFFFF))
                stat_cpu_wr_cnt <= stat_cpu_wr_cnt + 16'd1;
            if (forced && (stat_starve_hits != 16'hFFFF))
                stat_starve_hits <= stat_starve_hits + 16'd1;
        end
    end
`endif

endmodule : vram_arbiter
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Directed self-checking bench for vram_arbiter. Inputs change
//             1 time unit after the rising edge; outputs are sampled on the
//             falling edge. The BRAM model returns addr[7:0] one cycle after
//             a read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vg_req;
    logic [12:0] vg_addr;
    logic        vg_gnt, vg_rvalid;
    logic [7:0]  vg_rdata;
    logic        bram_en, bram_we;
    logic [12:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic [7:0]  bram_rdata = 8'h00;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stat_cpu_wr_cnt, stat_starve_hits;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bram_en && !bram_we) bram_rdata <= bram_addr[7:0];
    end

    vram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vg_req     (vg_req),
        .vg_addr    (vg_addr),
        .vg_gnt     (vg_gnt),
        .vg_rvalid  (vg_rvalid),
        .vg_rdata   (vg_rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_cpu_wr_cnt  (stat_cpu_wr_cnt),
        .stat_starve_hits (stat_starve_hits)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] t3_cpu_exp;
`ifdef VRAM_ARB_STATS_EN
    logic [7:0] wr_data [5];
`endif

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vg_req = 1'b0; vg_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cpu_gnt", 32'(cpu_gnt), 0);
        check("rst_vg_gnt", 32'(vg_gnt), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_vg_rvalid", 32'(vg_rvalid), 0);
        check("rst_bram_en", 32'(bram_en), 0);
        check("rst_bram_we", 32'(bram_we), 0);
        check("rst_bram_addr", 32'(bram_addr), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_vg_rdata", 32'(vg_rdata), 0);

        // Test 1: single CPU write
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'hA5;
        @(negedge clk);
        check("t1_cpu_gnt", 32'(cpu_gnt), 1);
        check("t1_vg_gnt", 32'(vg_gnt), 0);
        check("t1_bram_en", 32'(bram_en), 1);
        check("t1_bram_we", 32'(bram_we), 1);
        check("t1_bram_addr", 32'(bram_addr), 32'h0010);
        check("t1_bram_wdata", 32'(bram_wdata), 32'hA5);
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;
        @(negedge clk);
        check("t1_no_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("t1_no_vg_rvalid", 32'(vg_rvalid), 0);
        check("t1_idle_bram_en", 32'(bram_en), 0);
        check("t1_idle_bram_wdata", 32'(bram_wdata), 0);

        // Test 2: VG read 0x0100 and CPU read 0x0200 together
        next_cycle();
        vg_req = 1'b1; vg_addr = 13'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200;
        @(negedge clk);
        check("t2_c0_vg_gnt", 32'(vg_gnt), 1);
        check("t2_c0_cpu_gnt", 32'(cpu_gnt), 0);
        check("t2_c0_bram_addr", 32'(bram_addr), 32'h0100);
        check("t2_c0_bram_we", 32'(bram_we), 0);
        next_cycle();
        vg_req = 1'b0;
        @(negedge clk);
        check("t2_c1_vg_rvalid", 32'(vg_rvalid), 1);
        check("t2_c1_vg_rdata", 32'(vg_rdata), 32'h00);
        check("t2_c1_cpu_gnt", 32'(cpu_gnt), 1);
        check("t2_c1_bram_addr", 32'(bram_addr), 32'h0200);
        check("t2_c1_cpu_rvalid", 32'(cpu_rvalid), 0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("t2_c2_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("t2_c2_cpu_rdata", 32'(cpu_rdata), 32'h00);
        check("t2_c2_vg_rvalid", 32'(vg_rvalid), 0);

        // Test 2b: alternating back-to-back reads with distinct data
        next_cycle();
        vg_req = 1'b1; vg_addr = 13'h0133;
        @(negedge clk);
        check("t2b_a_vg_gnt", 32'(vg_gnt), 1);
        next_cycle();
        vg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h02C7;
        @(negedge clk);
        check("t2b_b_vg_rvalid", 32'(vg_rvalid), 1);
        check("t2b_b_vg_rdata", 32'(vg_rdata), 32'h33);
        check("t2b_b_cpu_gnt", 32'(cpu_gnt), 1);
        next_cycle();
        cpu_req = 1'b0; vg_req = 1'b1; vg_addr = 13'h0155;
        @(negedge clk);
        check("t2b_c_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("t2b_c_cpu_rdata", 32'(cpu_rdata), 32'hC7);
        check("t2b_c_vg_rvalid", 32'(vg_rvalid), 0);
        check("t2b_c_vg_gnt", 32'(vg_gnt), 1);
        next_cycle();
        vg_req = 1'b0;
        @(negedge clk);
        check("t2b_d_vg_rdata", 32'(vg_rdata), 32'h55);
        check("t2b_d_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("t2b_d_cpu_hold", 32'(cpu_rdata), 32'hC7);

        // Test 3: VG held, CPU starves 4 cycles then bursts 3, VG regranted
        t3_cpu_exp = 9'b0_0111_0000;
        next_cycle();
        vg_req = 1'b1; vg_addr = 13'h0010;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0020; cpu_wdata = 8'h11;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) cpu_req = 1'b0;
            @(negedge clk);
            check($sformatf("t3_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'(t3_cpu_exp[k]));
            check($sformatf("t3_vg_gnt_%0d", k), 32'(vg_gnt), 32'(!t3_cpu_exp[k]));
            if (k == 4) check("t3_burst_addr", 32'(bram_addr), 32'h0020);
            next_cycle();
        end

        // Test 4: burst exits early when CPU drops its request
        vg_req = 1'b0; cpu_req = 1'b1; cpu_wdata = 8'h22; cpu_addr = 13'h0030;
        @(negedge clk);
        check("t4_clear_cpu_gnt", 32'(cpu_gnt), 1);
        next_cycle();
        vg_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t4_starve_cpu_gnt_%0d", k), 32'(cpu_gnt), (k == 4) ? 1 : 0);
            next_cycle();
        end
        cpu_req = 1'b0;
        @(negedge clk);
        check("t4_exit_vg_gnt", 32'(vg_gnt), 1);
        check("t4_exit_cpu_gnt", 32'(cpu_gnt), 0);
        next_cycle();
        cpu_req = 1'b1;
        @(negedge clk);
        check("t4_normal_cpu_gnt", 32'(cpu_gnt), 0);
        check("t4_normal_vg_gnt", 32'(vg_gnt), 1);
        next_cycle();
        cpu_req = 1'b0; vg_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;

        // Test 5: reset the cycle after a granted VG read
        next_cycle();
        vg_req = 1'b1; vg_addr = 13'h0144;
        @(negedge clk);
        check("t5_vg_gnt", 32'(vg_gnt), 1);
        next_cycle();
        vg_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t5_rst_vg_rvalid", 32'(vg_rvalid), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_vg_rvalid", 32'(vg_rvalid), 0);
        check("t5_post_vg_rdata", 32'(vg_rdata), 0);
        check("t5_post_cpu_rdata", 32'(cpu_rdata), 0);
        check("t5_post_bram_en", 32'(bram_en), 0);
        next_cycle();
        vg_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        @(negedge clk);
        check("t5_normal_vg_gnt", 32'(vg_gnt), 1);
        check("t5_normal_cpu_gnt", 32'(cpu_gnt), 0);
        next_cycle();
        vg_req = 1'b0; cpu_req = 1'b0;

`ifdef VRAM_ARB_STATS_EN
        // Test 6: statistics counters
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_wr_cnt", 32'(stat_cpu_wr_cnt), 0);
        check("t6_rst_hits", 32'(stat_starve_hits), 0);
        wr_data[0] = 8'h00; wr_data[1] = 8'h01; wr_data[2] = 8'h00;
        wr_data[3] = 8'h02; wr_data[4] = 8'h03;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'(i); cpu_wdata = wr_data[i];
            @(negedge clk);
            check($sformatf("t6_wr_gnt_%0d", i), 32'(cpu_gnt), 1);
            next_cycle();
        end
        cpu_req = 1'b0; cpu_wdata = 8'h00;
        @(negedge clk);
        check("t6_wr_cnt", 32'(stat_cpu_wr_cnt), 3);
        next_cycle();
        vg_req = 1'b1; cpu_req = 1'b1;
        repeat (5) next_cycle();
        vg_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("t6_starve_hits", 32'(stat_starve_hits), 1);
        check("t6_wr_cnt_after", 32'(stat_cpu_wr_cnt), 3);
        next_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vram_arbiter
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single vector-RAM BRAM port (CPU window 0x2000-0x3FFF, 8 KB) between the 6502 side (decoder and store-queue drain) and the vector generator fetch engine.
- The VG has default priority to keep display timing.
- A saturating starvation counter and a short CPU burst state guarantee the CPU bounded access.
- Read data returns on a 1-cycle registered pipeline tagged to the granted owner.

Parameters:
- ADDR_W, 13, word address width of vector RAM.
- DATA_W, 8, data width.
- STARVE_MAX, 4, consecutive denied CPU-request cycles before the CPU wins contention.
- CPU_BURST_LEN, 3, maximum consecutive CPU grants once the CPU wins via starvation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU access request, held with fields stable until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address, offset from 0x2000.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data.
- vg_req  in  1  VG read request, held until vg_gnt.
- vg_addr  in  ADDR_W  VG address.
- vg_gnt  out  1  access performed this cycle.
- vg_rvalid  out  1  vg_rdata valid.
- vg_rdata  out  DATA_W  read data.
- bram_en  out  1  port enable.
- bram_we  out  1  port write enable.
- bram_addr  out  ADDR_W  port address.
- bram_wdata  out  DATA_W  port write data.
- bram_rdata  in  DATA_W  port read data, 1-cycle latency.

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: all gnt/rvalid/bram_en/bram_we = 0; rdata outputs = 0; starvation counter = 0; burst counter = 0; FSM = NORMAL.
- Grants are combinational from req and registered state. The transfer occurs in the cycle gnt=1, and at most one gnt is high per cycle.
- BRAM outputs are driven combinationally from the winner. When there is no winner, bram_en = 0 and addr/wdata = 0.
- FSM state NORMAL:
  - vg_req → VG wins.
  - Otherwise cpu_req → CPU wins.
  - Exception: if cpu_req and starve_cnt == STARVE_MAX, the CPU wins even with vg_req high. The FSM then goes to CPU_BURST with burst_cnt = 1.
- FSM state CPU_BURST:
  - CPU wins while cpu_req = 1 and burst_cnt < CPU_BURST_LEN; burst_cnt increments per grant.
  - Return to NORMAL when cpu_req = 0 or burst_cnt == CPU_BURST_LEN. That cycle is arbitrated as in NORMAL.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, each cycle cpu_req && !cpu_gnt.
  - Clears on any cpu_gnt.
  - Holds when cpu_req = 0.
- Read return pipeline:
  - A registered owner tag is set on a granted read: 2'b01 = CPU, 2'b10 = VG, 0 = none/write.
  - Next cycle: the owner's rvalid = 1 and its rdata is loaded from bram_rdata and held until its next read.
  - The non-owner's rvalid = 0.
  - Writes produce no rvalid.
- Back-to-back reads from alternating owners are supported every cycle with no bubbles.
- A requester dropping req without a gnt is legal; the starvation counter stops incrementing.
- Reset mid-operation: a pending rvalid is discarded (no rvalid next cycle) and the FSM returns to NORMAL.
- VG writes are not supported; VG accesses are always reads.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_cpu_wr_cnt (16b), counting granted CPU writes with nonzero data, saturating at 0xFFFF.
  - Adds stat_starve_hits (16b), counting starvation-forced wins, saturating at 0xFFFF.
  - Both clear on rst.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- The shared package (vram_pkg) holds:
  - owner_t enum (OWN_NONE, OWN_CPU, OWN_VG);
  - arb_state_t enum (NORMAL, CPU_BURST);
  - VRAM_BASE = 16'h2000 and VRAM_ADDR_W constants.
- Natural sub-module: vram_rd_return, the owner-tag register, rvalid/rdata capture and holding registers.

Test Plan:
- Test 1, idle then single CPU write (cpu_we=1, cpu_addr=0x0010, cpu_wdata=0xA5), no vg_req: expect cpu_gnt, bram_en=1, bram_we=1, bram_addr=0x0010, bram_wdata=0xA5 in the same cycle; no rvalid next cycle.
- Test 2, VG read of 0x0100 and CPU read of 0x0200 requested together, bram model returns addr[7:0]:
  - Cycle 0: vg_gnt.
  - Cycle 1: vg_rvalid with vg_rdata=0x00, and cpu_gnt.
  - Cycle 2: cpu_rvalid with cpu_rdata=0x00, data of 0x0200.
- Test 3, vg_req held continuously and CPU writes queued:
  - CPU denied 4 cycles (starve_cnt reaches 4), then granted 3 consecutive cycles (CPU_BURST).
  - VG regranted on the next cycle; starve_cnt back to 0.
- Test 4, CPU_BURST early exit: cpu_req drops after 1 burst grant → FSM back to NORMAL and VG granted that same cycle.
- Test 5, rst asserted the cycle after a granted VG read: vg_rvalid=0 the following cycle, all outputs at reset values, FSM NORMAL.
- Test 6, stats, VRAM_ARB_STATS_EN defined: 5 CPU writes with data {0,1,0,2,3} → stat_cpu_wr_cnt=3; one forced win → stat_starve_hits=1.
